multiplication_job_queue: RTL

Upstream feeder and downstream collector for `sequential_multiplicator`. Buffers operand pairs in a small FIFO and launches one multiplication at a time by driving the multiplier's operands and a one-cycle `start_in` pulse. After a fixed latency it captures `product_out` and presents the result on a valid/ready output port. The block owns all sequencing around the multiplier, so the surrounding logic only sees two streaming handshakes.

---
 rtl/multiplication_job_queue_if.sv | 39 +++
 rtl/multiplication_job_queue.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/multiplication_job_queue_if.sv
// Streaming handshakes around the multiplication job queue: operand intake and result output.
// Latency: none, this is wiring only.
// Backpressure: op_ready_out throttles the producer; result_ready_in stalls the result port.
interface multiplication_job_queue_if #(
    parameter int WIDTH = 8
);
    // Operand intake channel.
    logic               op_valid_in;
    logic               op_ready_out;
    logic [WIDTH-1:0]   multiplicand_op_in;
    logic [WIDTH-1:0]   multiplier_op_in;

    // Result delivery channel.
    logic               result_valid_out;
    logic               result_ready_in;
    logic [2*WIDTH-1:0] result_out;

    // Environment side: produces operands, consumes results.
    modport master (
        output op_valid_in,
        output multiplicand_op_in,
        output multiplier_op_in,
        output result_ready_in,
        input  op_ready_out,
        input  result_valid_out,
        input  result_out
    );

    // Queue side: accepts operands, produces results.
    modport slave (
        input  op_valid_in,
        input  multiplicand_op_in,
        input  multiplier_op_in,
        input  result_ready_in,
        output op_ready_out,
        output result_valid_out,
        output result_out
    );
endinterface

// File: rtl/multiplication_job_queue.sv
// Feeds a sequential multiplier from an operand FIFO and returns its products on a valid/ready port.
// Latency: push edge a -> LAUNCH in cycle a+2 -> result valid in cycle a+3+MUL_LATENCY.
// Backpressure: op_ready_out drops when the FIFO is full; the FSM parks in HOLD until result_ready_in.
// Optional: define MULTIPLICATION_JOB_QUEUE_STATS_EN to add the saturating jobs_done_out counter.
module multiplication_job_queue #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int MUL_LATENCY = WIDTH + 1
) (
    input  logic                         clock,
    input  logic                         reset_in,

    multiplication_job_queue_if.slave    bus,

    output logic [WIDTH-1:0]             multiplicand_out,
    output logic [WIDTH-1:0]             multiplier_out,
    output logic                         start_out,
    input  logic [2*WIDTH-1:0]           product_in,

    output logic [$clog2(DEPTH+1)-1:0]   count_out,
    output logic                         busy_out
`ifdef MULTIPLICATION_JOB_QUEUE_STATS_EN
    ,
    output logic [15:0]                  jobs_done_out
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int LAT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(DEPTH);
    localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'(MUL_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Operand FIFO
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;

    // ------------------------------------------------------------------
    // Sequencing state
    // ------------------------------------------------------------------
    state_t             state_q,  state_d;
    logic [LAT_W-1:0]   wait_q,   wait_d;
    logic [WIDTH-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic op_ready;
    logic push;
    logic pop;
    logic result_hs;

    // Ready depends only on the registered occupancy, so a full FIFO refuses
    // a push even when the FSM pops on the same edge.
    assign op_ready  = (count_q != FULL_LEVEL);
    assign push      = bus.op_valid_in && op_ready;
    assign pop       = (state_q == IDLE) && (count_q != '0);
    assign result_hs = (state_q == HOLD) && bus.result_ready_in;

    // FIFO pointer and occupancy next-state; pointers wrap naturally at DEPTH (power of 2).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage write; contents need no reset since occupancy gates every read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.multiplicand_op_in, bus.multiplier_op_in};
        end
    end

    // FIFO pointer and occupancy registers.
    always_ff @(posedge clock) begin
        if (reset_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FSM next-state: pop in IDLE, pulse start in LAUNCH, count down in WAIT, present in HOLD.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    {mcand_d, mplier_d} = mem_q[rd_ptr_q];
                    state_d             = LAUNCH;
                end
            end
            LAUNCH: begin
                wait_d  = LAT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                // The multiplier's product is valid in the cycle the counter reads zero.
                if (wait_q == '0) begin
                    result_d = product_in;
                    state_d  = HOLD;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            HOLD: begin
                if (bus.result_ready_in) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, operand and result registers; a reset drops any in-flight job.
    always_ff @(posedge clock) begin
        if (reset_in) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
        end
    end

`ifdef MULTIPLICATION_JOB_QUEUE_STATS_EN
    logic [15:0] jobs_done_q, jobs_done_d;

    // Completed-job counter, saturating at all ones.
    always_comb begin
        jobs_done_d = jobs_done_q;
        if (result_hs && (jobs_done_q != 16'hFFFF)) begin
            jobs_done_d = jobs_done_q + 16'd1;
        end
    end

    // Completed-job counter register.
    always_ff @(posedge clock) begin
        if (reset_in) begin
            jobs_done_q <= '0;
        end else begin
            jobs_done_q <= jobs_done_d;
        end
    end

    assign jobs_done_out = jobs_done_q;
`else
    // Handshake term is only consumed by the statistics counter.
    logic unused_result_hs;
    assign unused_result_hs = result_hs;
`endif

    // All outputs decode registered state only; no input reaches an output combinationally.
    assign bus.op_ready_out     = op_ready;
    assign bus.result_valid_out = (state_q == HOLD);
    assign bus.result_out       = result_q;
    assign multiplicand_out     = mcand_q;
    assign multiplier_out       = mplier_q;
    assign start_out            = (state_q == LAUNCH);
    assign count_out            = count_q;
    assign busy_out             = (state_q != IDLE);

endmodule
